// File: rtl/histogram_builder.sv
// histogram_builder: 256-bin luminance histogram of each frame, accumulated
// into one bank of a ping-pong RAM while the completed bank is read out.
// Counts saturate at 2^CW-1; the largest bin of the completed frame is
// published on oMaxValue when the banks swap.
module histogram_builder #(
    parameter int BINS   = 256,
    parameter int CW     = 20,
    parameter int ADDR_W = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [ADDR_W-1:0] iPixel,
    input  logic              iFrameEnd,
    input  logic [ADDR_W-1:0] iHistoAddr,
    output logic [CW-1:0]     oHistoValue,
    output logic [CW-1:0]     oMaxValue,
    output logic              oFrameDone,
    output logic              oReady,
    output logic              oOverrun
);

    localparam logic [2:0] ST_CLR_BOTH = 3'd0;
    localparam logic [2:0] ST_ACCUM    = 3'd1;
    localparam logic [2:0] ST_FLUSH    = 3'd2;
    localparam logic [2:0] ST_SWAP     = 3'd3;
    localparam logic [2:0] ST_CLR      = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_bank_q;

    logic              s0_valid_q, s1_valid_q;
    logic [ADDR_W-1:0] s0_bin_q, s1_bin_q;
    logic [CW-1:0]     s1_val_q;

    logic [CW-1:0]     run_max_q;
    logic [CW-1:0]     max_value_q;
    logic [CW-1:0]     histo_value_q;
    logic              overrun_q;

    logic [CW-1:0]     bank0_q [BINS];
    logic [CW-1:0]     bank1_q [BINS];

    logic [CW-1:0]     s0_old;
    logic [CW:0]       s0_wide;
    logic [CW-1:0]     s0_inc;

    logic              we0, we1;
    logic [ADDR_W-1:0] wr_addr;
    logic [CW-1:0]     wr_data;

    // Sequencing: clear both banks, accumulate, drain the pipe, swap, clear.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLR_BOTH, ST_CLR: begin
                cnt_d = cnt_q + 1'b1;  // wraps back to 0 after the last bin
                if (cnt_q == LAST_BIN) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (iFrameEnd) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(1)) begin
                    state_d = ST_SWAP;
                    cnt_d   = '0;
                end
            end
            ST_SWAP: begin
                state_d = ST_CLR;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_CLR_BOTH;
                cnt_d   = '0;
            end
        endcase
    end

    // S0 read with forwarding from S1, then saturating increment.
    always_comb begin
        if (s1_valid_q && (s1_bin_q == s0_bin_q)) s0_old = s1_val_q;
        else if (wr_bank_q)                       s0_old = bank1_q[s0_bin_q];
        else                                      s0_old = bank0_q[s0_bin_q];
        s0_wide = {1'b0, s0_old} + 1'b1;
        s0_inc  = s0_wide[CW] ? s0_old : s0_wide[CW-1:0];
    end

    // Write-port steering: clear sweeps take priority, else the S1 update.
    always_comb begin
        we0     = 1'b0;
        we1     = 1'b0;
        wr_addr = s1_bin_q;
        wr_data = s1_val_q;
        if (state_q == ST_CLR_BOTH) begin
            we0     = 1'b1;
            we1     = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (state_q == ST_CLR) begin
            we0     = ~wr_bank_q;
            we1     = wr_bank_q;
            wr_addr = cnt_q;
            wr_data = '0;
        end else if (s1_valid_q) begin
            we0 = ~wr_bank_q;
            we1 = wr_bank_q;
        end
    end

    // Control state, pipeline, running max and status registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q       <= ST_CLR_BOTH;
            cnt_q         <= '0;
            wr_bank_q     <= 1'b0;
            s0_valid_q    <= 1'b0;
            s1_valid_q    <= 1'b0;
            s0_bin_q      <= '0;
            s1_bin_q      <= '0;
            s1_val_q      <= '0;
            run_max_q     <= '0;
            max_value_q   <= '0;
            histo_value_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s0_valid_q <= iValid && (state_q == ST_ACCUM);
            s0_bin_q   <= iPixel;
            s1_valid_q <= s0_valid_q;
            s1_bin_q   <= s0_bin_q;
            s1_val_q   <= s0_inc;
            if (state_q == ST_SWAP) begin
                wr_bank_q   <= ~wr_bank_q;
                max_value_q <= run_max_q;
                run_max_q   <= '0;
            end else if (s1_valid_q && (s1_val_q > run_max_q)) begin
                run_max_q <= s1_val_q;
            end
            if (iValid && (state_q != ST_ACCUM)) overrun_q <= 1'b1;
            histo_value_q <= wr_bank_q ? bank0_q[iHistoAddr] : bank1_q[iHistoAddr];
        end
    end

    // Bank 0 storage.
    always_ff @(posedge iClk) begin
        // NOTE: the RAM arrays have no reset branch; the clear sweep after
        // reset zeroes them, which keeps them mappable to block RAM.
        if (we0) bank0_q[wr_addr] <= wr_data;
    end

    // Bank 1 storage.
    always_ff @(posedge iClk) begin
        if (we1) bank1_q[wr_addr] <= wr_data;
    end

    assign oHistoValue = histo_value_q;
    assign oMaxValue   = max_value_q;
    assign oFrameDone  = (state_q == ST_SWAP);
    assign oReady      = (state_q == ST_ACCUM);
    assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_histogram_builder.sv
// tb_histogram_builder: directed and randomized frames checked against a
// per-bin counting model of the completed and in-progress histograms.
module tb_histogram_builder;

    localparam int unsigned MAXC = (1 << 20) - 1;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic [7:0]  iPixel = '0;
    logic        iFrameEnd = 1'b0;
    logic [7:0]  iHistoAddr = '0;
    logic [19:0] oHistoValue;
    logic [19:0] oMaxValue;
    logic        oFrameDone;
    logic        oReady;
    logic        oOverrun;

    int unsigned model_wr [256];
    int unsigned model_rd [256];
    int          vectors = 0;
    int          miscompares = 0;

    histogram_builder dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .iPixel     (iPixel),
        .iFrameEnd  (iFrameEnd),
        .iHistoAddr (iHistoAddr),
        .oHistoValue(oHistoValue),
        .oMaxValue  (oMaxValue),
        .oFrameDone (oFrameDone),
        .oReady     (oReady),
        .oOverrun   (oOverrun)
    );

    always #5 iClk = ~iClk;

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_max();
        int unsigned m = 0;
        for (int b = 0; b < 256; b++) if (model_wr[b] > m) m = model_wr[b];
        return m;
    endfunction

    function automatic void model_count(input logic [7:0] p);
        if (model_wr[p] < MAXC) model_wr[p]++;
    endfunction

    task automatic send_pixel(input logic [7:0] p);
        iValid = 1'b1;
        iPixel = p;
        step();
        iValid = 1'b0;
        model_count(p);
    endtask

    task automatic send_run(input logic [7:0] p, input int n);
        for (int i = 0; i < n; i++) send_pixel(p);
    endtask

    // Reset, then measure how long the clear sweep holds oReady low.
    task automatic do_reset();
        iRst = 1'b1;
        iValid = 1'b0;
        iFrameEnd = 1'b0;
        step();
        step();
        check("reset_max", oMaxValue, 0);
        check("reset_overrun", oOverrun, 0);
        check("reset_ready", oReady, 0);
        iRst = 1'b0;
        for (int b = 0; b < 256; b++) begin
            model_wr[b] = 0;
            model_rd[b] = 0;
        end
        begin
            int n = 0;
            while (!oReady && n < 1000) begin
                step();
                n++;
            end
            check("ready_latency", n, 256);
        end
    endtask

    // Pulse iFrameEnd (optionally with a last pixel), check the swap timing
    // and the published maximum, then move the model to the completed bank.
    task automatic end_frame(input bit with_pix, input logic [7:0] p);
        int unsigned exp_max;
        int n;
        iFrameEnd = 1'b1;
        iValid = with_pix;
        iPixel = p;
        if (with_pix) model_count(p);
        step();
        iFrameEnd = 1'b0;
        iValid = 1'b0;
        n = 1;
        while (!oFrameDone && n < 10) begin
            step();
            n++;
        end
        check("frame_done_latency", n, 3);
        exp_max = model_max();
        step();
        check("frame_done_pulse", oFrameDone, 0);
        check("max_value", oMaxValue, exp_max);
        for (int b = 0; b < 256; b++) begin
            model_rd[b] = model_wr[b];
            model_wr[b] = 0;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!oReady && n < 600) begin
            step();
            n++;
        end
        check("wait_ready", oReady, 1);
    endtask

    task automatic read_bin(input string tag, input logic [7:0] a);
        iHistoAddr = a;
        step();
        check(tag, oHistoValue, model_rd[a]);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 256; a++) begin
            iHistoAddr = 8'(a);
            step();
            check(tag, oHistoValue, model_rd[a]);
        end
    endtask

    initial begin
        logic [7:0] last_pix;

        // 1: reset state, clear sweep length, both banks empty
        do_reset();
        check("init_max", oMaxValue, 0);
        read_all("init_bins");

        // 2: long run of one value
        send_run(8'h80, 1000);
        end_frame(1'b0, 8'h00);
        read_all("run_0x80");
        wait_ready();

        // 3: interleaved repeats exercise forwarding
        for (int r = 0; r < 100; r++) begin
            send_pixel(8'h10);
            send_pixel(8'h10);
            send_pixel(8'h20);
            send_pixel(8'h10);
        end
        end_frame(1'b0, 8'h00);
        read_all("fwd_pattern");
        wait_ready();

        // 4: completed bank stays readable while the next frame accumulates
        send_run(8'h05, 500);
        end_frame(1'b0, 8'h00);
        wait_ready();
        send_run(8'h06, 200);
        read_bin("pingpong_a5", 8'h05);
        read_bin("pingpong_a6", 8'h06);
        end_frame(1'b0, 8'h00);
        read_bin("pingpong_b5", 8'h05);
        read_bin("pingpong_b6", 8'h06);
        check("overrun_clean", oOverrun, 0);

        // 5: pixel during the clear sweep is dropped and flags overrun
        for (int i = 0; i < 47; i++) step();
        iValid = 1'b1;
        iPixel = 8'h33;
        step();
        iValid = 1'b0;
        check("overrun_set", oOverrun, 1);
        wait_ready();
        send_run(8'h44, 10);
        end_frame(1'b1, 8'h44);
        read_all("after_drop");
        check("overrun_sticky", oOverrun, 1);
        wait_ready();

        // empty frame
        end_frame(1'b0, 8'h00);
        read_all("empty_frame");
        wait_ready();

        // 6: saturation from a preloaded near-full bin
        dut.bank0_q[255] = 20'hFFFFE;
        dut.bank1_q[255] = 20'hFFFFE;
        model_wr[255] = MAXC - 1;
        send_run(8'hFF, 3);
        send_pixel(8'h01);
        end_frame(1'b0, 8'h00);
        read_bin("sat_bin", 8'hFF);
        read_bin("sat_other", 8'h01);
        wait_ready();

        // randomized frames with gaps, repeats and a pixel on the frame end
        last_pix = 8'h00;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 300; i++) begin
                case ($urandom_range(0, 3))
                    0: step();
                    1: send_pixel(last_pix);
                    2: begin
                        last_pix = 8'($urandom_range(0, 7));
                        send_pixel(last_pix);
                    end
                    default: begin
                        last_pix = 8'($urandom_range(0, 255));
                        send_pixel(last_pix);
                    end
                endcase
            end
            end_frame(1'b1, 8'($urandom_range(0, 7)));
            read_all("random_frame");
            check("overrun_still", oOverrun, 1);
            wait_ready();
        end

        // 7: reset mid-frame discards partial counts
        send_run(8'h22, 100);
        do_reset();
        read_all("post_reset_bins");
        send_run(8'h22, 7);
        send_run(8'h23, 3);
        end_frame(1'b0, 8'h00);
        read_all("post_reset_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/histogram_builder.md
Name: histogram_builder

Overview:
- Builds the 256-bin luminance histogram of each camera frame from the 8-bit pixel stream.
- Accumulates into one bank of a ping-pong RAM. The histogram display path reads the other, completed bank through a registered read port, with the frame maximum for normalisation.
- Sits between the greyscale pixel pipeline and the histogram display/threshold logic.

Parameters:
- BINS, 256, number of bins; fixed by the 8-bit pixel width.
- CW, 20, bin counter width; counts saturate at 2^CW-1.
- ADDR_W, 8, bin address width.

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous active-high reset
- iValid  in  1  iPixel qualifier
- iPixel  in  8  pixel luminance; selects the bin
- iFrameEnd  in  1  one-cycle pulse after the last pixel of a frame
- iHistoAddr  in  8  read address into the completed bank
- oHistoValue  out  20  count of bin iHistoAddr, completed bank
- oMaxValue  out  20  largest bin count of the completed frame
- oFrameDone  out  1  one-cycle pulse when the banks swap
- oReady  out  1  high when pixels are accepted (ACCUM state)
- oOverrun  out  1  sticky; a valid pixel was dropped

Behaviour:
- Reset, synchronous: state <= CLR_BOTH; wr_bank <= 0; oHistoValue, oMaxValue, running max <= 0; oFrameDone, oReady, oOverrun <= 0. Reset mid-frame discards all partial counts.
- CLR_BOTH: writes 0 to bin k of both banks, k = 0..255, one bin per cycle. 256 cycles, then ACCUM.
- ACCUM: oReady = 1. Each valid pixel goes through a 2-stage read-modify-write:
  - S0 (cycle t+1): register bin, read write-bank RAM.
  - S1 (cycle t+2): write value+1 to the bin.
- Throughput is one pixel per cycle, back-to-back, including repeats of the same bin.
- Forwarding: if the S0 bin equals the S1 bin, S0 uses the S1 incremented value instead of stale RAM data. Consecutive identical pixels must count exactly.
- Saturation: a bin at 2^20-1 stays at 2^20-1. No wrap.
- Running max: updated in S1 to max(running, incremented value).
- iFrameEnd in ACCUM: a pixel valid in the same cycle is counted. Go to FLUSH for 2 cycles to drain S0/S1, then SWAP.
- SWAP, 1 cycle:
  - wr_bank toggles.
  - oMaxValue <= final running max; running max <= 0.
  - oFrameDone = 1 for this cycle.
  - Next state CLR.
- CLR: zeroes all 256 bins of the new write bank, 256 cycles, then ACCUM. The read bank is untouched.
- Frame period: iFrameEnd to first accepted pixel is 2+1+256 = 259 cycles minimum. Camera blanking covers this.
- Dropped pixels: iValid while oReady = 0 (CLR_BOTH, FLUSH, SWAP, CLR) is dropped and sets oOverrun. oOverrun clears only on iRst.
- iFrameEnd outside ACCUM is ignored.
- Read port:
  - oHistoValue <= read_bank[iHistoAddr], 1-cycle latency, every cycle.
  - The new bank is visible on reads issued in the cycle after the SWAP cycle.
  - Reads of the write bank are never possible.
- A frame with no pixels completes: all bins 0, oMaxValue = 0.
- Widths: all counts are 20-bit unsigned; the increment is computed at 21 bits for the saturation compare.

Test Plan:
1. Reset, wait 256 cycles, read all 256 addresses -> every oHistoValue = 0, oMaxValue = 0, oReady rises exactly 256 cycles after reset deasserts.
2. Stream 1000 back-to-back pixels of value 0x80, then iFrameEnd -> oFrameDone 3 cycles later. Reading address 0x80 gives 1000; all other bins 0; oMaxValue = 1000.
3. Alternating 0x10,0x10,0x20,0x10 repeated 100 times, no gaps -> bin 0x10 = 300, bin 0x20 = 100, oMaxValue = 300. Checks forwarding.
4. Frame A (500 × 0x05), swap, then frame B (200 × 0x06) in progress -> during B, reads return bin 0x05 = 500 and bin 0x06 = 0. After B's swap: bin 0x05 = 0, bin 0x06 = 200, oMaxValue = 200.
5. Pixel valid during CLR (50 cycles after oFrameDone) -> pixel not counted, oOverrun = 1 and stays 1 through subsequent frames until iRst.
6. Force bin 0xFF to 2^20-2 (hierarchical preload), feed 3 pixels of 0xFF -> bin 0xFF = 0xFFFFF, oMaxValue = 0xFFFFF.
7. Assert iRst mid-frame after 100 pixels -> oMaxValue = 0, oReady = 0 for 256 cycles, then a fresh frame counts from 0.
